efuse_shadow_load: RTL and testbench



---
 rtl/efuse_shadow_load_if.sv | 40 ++++
 rtl/efuse_shadow_load.sv | 137 +++++++++++++
 tb/tb_efuse_shadow_load.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/efuse_shadow_load_if.sv
// Autoload / register-interface bundle for efuse_shadow_load.
// master = stimulus/controller side, slave = shadow loader.
interface efuse_shadow_load_if #(
  parameter int NR         = 64,
  parameter int TOTAL_BITS = 256
);
  localparam int SW = (TOTAL_BITS / NR > 1) ? $clog2(TOTAL_BITS / NR) : 1;

  logic                  efuse_autoload_vld;
  logic [NR-1:0]         efuse_autoload_data;
  logic                  efuse_autoload_done;
  logic                  rg_shadow_reload;
  logic                  rg_shadow_ovr_en;
  logic                  rg_shadow_ovr_wr;
  logic [SW-1:0]         rg_shadow_ovr_sel;
  logic [NR-1:0]         rg_shadow_ovr_wdata;
  logic [TOTAL_BITS-1:0] shadow_data;
  logic                  shadow_valid;
  logic                  shadow_chk_err;
  logic                  shadow_cnt_err;
  logic                  shadow_lock;
  logic                  shadow_ovr_blocked;
  logic                  shadow_reload_req;

  modport slave (
    input  efuse_autoload_vld, efuse_autoload_data, efuse_autoload_done,
    input  rg_shadow_reload, rg_shadow_ovr_en, rg_shadow_ovr_wr,
    input  rg_shadow_ovr_sel, rg_shadow_ovr_wdata,
    output shadow_data, shadow_valid, shadow_chk_err, shadow_cnt_err,
    output shadow_lock, shadow_ovr_blocked, shadow_reload_req
  );

  modport master (
    output efuse_autoload_vld, efuse_autoload_data, efuse_autoload_done,
    output rg_shadow_reload, rg_shadow_ovr_en, rg_shadow_ovr_wr,
    output rg_shadow_ovr_sel, rg_shadow_ovr_wdata,
    input  shadow_data, shadow_valid, shadow_chk_err, shadow_cnt_err,
    input  shadow_lock, shadow_ovr_blocked, shadow_reload_req
  );
endinterface

// File: rtl/efuse_shadow_load.sv
// efuse_shadow_load: captures the efuse autoload stream into a shadow bank,
// checks the XOR checksum byte (top byte of the image) and the beat count,
// registers the lock bit, and serves a lock-gated software override plus a
// reload request back to the efuse controller.
// Optional macro SHADOW_DEFAULT_ON_ERR_EN: in ERR the presented image is
// DEFAULT_VAL instead of the bank (the bank itself is kept and still writable).
module efuse_shadow_load #(
  parameter int                    NR          = 64,
  parameter int                    TOTAL_BITS  = 256,
  parameter logic [TOTAL_BITS-1:0] DEFAULT_VAL = '0
) (
  input logic                clk,
  input logic                rst_n,
  efuse_shadow_load_if.slave bus
);
  localparam int NWORD = TOTAL_BITS / NR;
  localparam int NBYTE = NR / 8;
  localparam int CW    = $clog2(NWORD + 1);
  localparam int SW    = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam logic [CW-1:0] NWORD_C = CW'(NWORD);
  localparam logic [CW-1:0] LAST_C  = CW'(NWORD - 1);

  // Elaboration-time sanity of the geometry.
  if ((TOTAL_BITS % NR) != 0 || (NR % 8) != 0 || NWORD < 2 ||
      $bits(DEFAULT_VAL) != TOTAL_BITS) begin : g_bad_cfg
    $error("efuse_shadow_load: unsupported NR/TOTAL_BITS");
  end

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

  state_t                      state_q, state_d;
  logic [NWORD-1:0][NR-1:0]    bank_q;
  logic [CW-1:0]               cnt_q;
  logic [7:0]                  xor_q;
  logic                        ovf_q, chk_err_q, cnt_err_q, lock_q;
  logic                        reload_req_q, blocked_q;

  logic result_st, cap, ovf_ev, reload_acc, ovr_acc, ovr_blk;
  logic chk_bad, cnt_bad;

  // XOR of all bytes of a beat; the checksum byte is skipped on the last word.
  function automatic logic [7:0] beat_xor(input logic [NR-1:0] d, input logic last);
    logic [7:0] x;
    x = '0;
    for (int b = 0; b < NBYTE; b++)
      if (!(last && b == NBYTE - 1)) x ^= d[b*8 +: 8];
    return x;
  endfunction

  assign result_st  = (state_q == DONE) || (state_q == ERR);
  assign cap        = bus.efuse_autoload_vld &&
                      ((state_q == IDLE) || (state_q == LOAD && cnt_q < NWORD_C));
  assign ovf_ev     = bus.efuse_autoload_vld && state_q == LOAD && cnt_q == NWORD_C;
  assign reload_acc = bus.rg_shadow_reload && result_st;
  // Reload takes priority: a same-cycle override is dropped without a blocked pulse.
  assign ovr_acc    = bus.rg_shadow_ovr_wr && bus.rg_shadow_ovr_en && result_st &&
                      !lock_q && !reload_acc;
  assign ovr_blk    = bus.rg_shadow_ovr_wr && bus.rg_shadow_ovr_en && !reload_acc &&
                      (!result_st || lock_q);
  assign chk_bad    = xor_q != bank_q[NWORD-1][NR-1 -: 8];
  assign cnt_bad    = (cnt_q != NWORD_C) || ovf_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; done wins over vld so a same-cycle last beat goes to CHECK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.efuse_autoload_done) state_d = CHECK;
                  else if (bus.efuse_autoload_vld) state_d = LOAD;
      LOAD:       if (bus.efuse_autoload_done) state_d = CHECK;
      CHECK:      state_d = (chk_bad || cnt_bad) ? ERR : DONE;
      DONE, ERR:  if (reload_acc) state_d = LOAD;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs derived from state and status registers.
  always_comb begin
    bus.shadow_valid       = (state_q == DONE);
    bus.shadow_chk_err     = chk_err_q;
    bus.shadow_cnt_err     = cnt_err_q;
    bus.shadow_lock        = lock_q;
    bus.shadow_ovr_blocked = blocked_q;
    bus.shadow_reload_req  = reload_req_q;
`ifdef SHADOW_DEFAULT_ON_ERR_EN
    bus.shadow_data        = (state_q == ERR) ? DEFAULT_VAL : bank_q;
`else
    bus.shadow_data        = bank_q;
`endif
  end

  // Bank capture, running checksum, status flags and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q       <= '0;
      cnt_q        <= '0;
      xor_q        <= '0;
      ovf_q        <= 1'b0;
      chk_err_q    <= 1'b0;
      cnt_err_q    <= 1'b0;
      lock_q       <= 1'b0;
      reload_req_q <= 1'b0;
      blocked_q    <= 1'b0;
    end else begin
      reload_req_q <= reload_acc;
      blocked_q    <= ovr_blk;
      if (reload_acc) begin
        // Bank is left as-is; the new beats overwrite it.
        cnt_q     <= '0;
        xor_q     <= '0;
        ovf_q     <= 1'b0;
        chk_err_q <= 1'b0;
        cnt_err_q <= 1'b0;
        lock_q    <= 1'b0;
      end else begin
        if (cap) begin
          bank_q[cnt_q[SW-1:0]] <= bus.efuse_autoload_data;
          cnt_q                 <= cnt_q + 1'b1;
          xor_q                 <= xor_q ^ beat_xor(bus.efuse_autoload_data, cnt_q == LAST_C);
        end
        if (ovf_ev) ovf_q <= 1'b1;
        if (state_q == CHECK) begin
          chk_err_q <= chk_bad;
          cnt_err_q <= cnt_bad;
          lock_q    <= bank_q[NWORD-1][NR-9];
        end
        // Override touches the bank only; lock and checksum status stay put.
        if (ovr_acc) bank_q[bus.rg_shadow_ovr_sel] <= bus.rg_shadow_ovr_wdata;
      end
    end
  end
endmodule

// File: tb/tb_efuse_shadow_load.sv
// Scoreboard bench for efuse_shadow_load: stimulus pushes expected results,
// pulses and snapshots into queues; a negedge monitor pops and compares.
module tb_efuse_shadow_load;
  localparam int NR = 64;
  localparam int TB = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  efuse_shadow_load_if #(.NR(NR), .TOTAL_BITS(TB)) bus();
  efuse_shadow_load #(.NR(NR), .TOTAL_BITS(TB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          v, c, n, l;
    logic [TB-1:0] d;
    int            cy;
  } exp_t;

  exp_t res_q[$];
  exp_t snap_q[$];
  int   rr_q[$];
  int   blk_q[$];

  task automatic chk1(input string nm, input logic act, input logic ex);
    total++;
    if (act !== ex) begin bad++; $display("FAIL %s got=%0b want=%0b", nm, act, ex); end
  endtask

  task automatic chkd(input string nm, input logic [TB-1:0] act, input logic [TB-1:0] ex);
    total++;
    if (act !== ex) begin bad++; $display("FAIL %s got=%h want=%h", nm, act, ex); end
  endtask

  task automatic chki(input string nm, input int act, input int ex);
    total++;
    if (act != ex) begin bad++; $display("FAIL %s got=%0d want=%0d", nm, act, ex); end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=unexpected_or_missing want=none", nm);
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk1({tag, "_valid"}, bus.shadow_valid, e.v);
    chk1({tag, "_chk_err"}, bus.shadow_chk_err, e.c);
    chk1({tag, "_cnt_err"}, bus.shadow_cnt_err, e.n);
    chk1({tag, "_lock"}, bus.shadow_lock, e.l);
    chkd({tag, "_data"}, bus.shadow_data, e.d);
  endtask

  // Monitor: a result is presented when valid/err rises; pulses are matched by cycle.
  initial begin : mon
    logic prev;
    logic cur;
    exp_t e;
    int   x;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      cur = bus.shadow_valid | bus.shadow_chk_err | bus.shadow_cnt_err;
      if (cur && !prev) begin
        if (res_q.size() == 0) note_fail("res_extra");
        else begin
          e = res_q.pop_front();
          chki("res_latency", cyc, e.cy);
          cmp_out("res", e);
        end
      end
      prev = cur;
      if (bus.shadow_reload_req === 1'b1) begin
        if (rr_q.size() == 0) note_fail("reload_req_extra");
        else begin x = rr_q.pop_front(); chki("reload_req_cyc", cyc, x); end
      end
      if (bus.shadow_ovr_blocked === 1'b1) begin
        if (blk_q.size() == 0) note_fail("ovr_blocked_extra");
        else begin x = blk_q.pop_front(); chki("ovr_blocked_cyc", cyc, x); end
      end
      while (snap_q.size() != 0 && snap_q[0].cy <= cyc) begin
        e = snap_q.pop_front();
        chki("snap_cyc", cyc, e.cy);
        cmp_out("snap", e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  function automatic logic [TB-1:0] err_img(input logic [TB-1:0] raw);
`ifdef SHADOW_DEFAULT_ON_ERR_EN
    return '0;
`else
    return raw;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_res(input logic v, c, n, l, input logic [TB-1:0] d);
    exp_t e;
    e.v = v; e.c = c; e.n = n; e.l = l; e.d = d; e.cy = cyc + 2;
    res_q.push_back(e);
  endtask

  task automatic push_snap(input logic v, c, n, l, input logic [TB-1:0] d, input int off);
    exp_t e;
    e.v = v; e.c = c; e.n = n; e.l = l; e.d = d; e.cy = cyc + off;
    snap_q.push_back(e);
  endtask

  task automatic beat(input logic [NR-1:0] d, input logic dn);
    bus.efuse_autoload_vld  = 1'b1;
    bus.efuse_autoload_data = d;
    bus.efuse_autoload_done = dn;
    step();
    bus.efuse_autoload_vld  = 1'b0;
    bus.efuse_autoload_done = 1'b0;
  endtask

  task automatic done_only();
    bus.efuse_autoload_done = 1'b1;
    step();
    bus.efuse_autoload_done = 1'b0;
  endtask

  task automatic reload();
    bus.rg_shadow_reload = 1'b1;
    rr_q.push_back(cyc + 1);
    step();
    bus.rg_shadow_reload = 1'b0;
  endtask

  task automatic ovr(input logic [1:0] sel, input logic [NR-1:0] wd);
    bus.rg_shadow_ovr_en    = 1'b1;
    bus.rg_shadow_ovr_wr    = 1'b1;
    bus.rg_shadow_ovr_sel   = sel;
    bus.rg_shadow_ovr_wdata = wd;
    step();
    bus.rg_shadow_ovr_wr    = 1'b0;
    bus.rg_shadow_ovr_en    = 1'b0;
  endtask

  localparam logic [NR-1:0] W_A5   = 64'h00000000000000A5;
  localparam logic [NR-1:0] W_TOP  = 64'hA500000000000000;
  localparam logic [NR-1:0] W_BAD  = 64'hA400000000000000;
  localparam logic [NR-1:0] W_LOCK = 64'h8080000000000000;
  localparam logic [NR-1:0] W_OVR  = 64'h1122334455667788;
  localparam logic [NR-1:0] W_DEAD = 64'hDEADBEEF00000000;

  logic [TB-1:0] img_good, img_ovr, img_bad, img_err_ovr, img_lock;

  initial begin : stim
    img_good    = {W_TOP, 64'h0, 64'h0, W_A5};
    img_ovr     = {W_TOP, W_OVR, 64'h0, W_A5};
    img_bad     = {W_BAD, 64'h0, 64'h0, W_A5};
    img_err_ovr = {W_BAD, 64'h0, W_DEAD, W_A5};
    img_lock    = {W_LOCK, 64'h0, 64'h0, 64'h0};

    bus.efuse_autoload_vld  = 1'b0;
    bus.efuse_autoload_data = '0;
    bus.efuse_autoload_done = 1'b0;
    bus.rg_shadow_reload    = 1'b0;
    bus.rg_shadow_ovr_en    = 1'b0;
    bus.rg_shadow_ovr_wr    = 1'b0;
    bus.rg_shadow_ovr_sel   = '0;
    bus.rg_shadow_ovr_wdata = '0;

    // Reset state
    repeat (2) step();
    push_snap(0, 0, 0, 0, '0, 0);
    step();
    rst_n = 1'b1;
    step();

    // Good load
    beat(W_A5, 0); beat('0, 0); beat('0, 0); beat(W_TOP, 0);
    push_res(1, 0, 0, 0, img_good);
    done_only();
    repeat (3) step();

    // Override word 2 while DONE, lock=0
    push_snap(1, 0, 0, 0, img_ovr, 1);
    ovr(2'd2, W_OVR);
    repeat (2) step();

    // Reload in DONE, then fresh good load
    push_snap(0, 0, 0, 0, img_ovr, 1);
    reload();
    beat(W_A5, 0); beat('0, 0); beat('0, 0); beat(W_TOP, 0);
    push_res(1, 0, 0, 0, img_good);
    done_only();
    repeat (3) step();

    // Bad checksum
    reload();
    beat(W_A5, 0); beat('0, 0); beat('0, 0); beat(W_BAD, 0);
    push_res(0, 1, 0, 0, err_img(img_bad));
    done_only();
    repeat (3) step();

    // Override accepted in ERR (lock=0), no blocked pulse
    push_snap(0, 1, 0, 0, err_img(img_err_ovr), 1);
    ovr(2'd1, W_DEAD);
    repeat (2) step();

    // Three beats: short count, and top byte A4 no longer matches XOR A5
    reload();
    beat(W_A5, 0); beat('0, 0); beat('0, 0);
    push_res(0, 1, 1, 0, err_img(img_bad));
    done_only();
    repeat (3) step();

    // Five beats: fifth dropped, word 3 keeps the fourth beat
    reload();
    beat(W_A5, 0); beat('0, 0); beat('0, 0); beat(W_TOP, 0); beat(64'h77, 0);
    push_res(0, 0, 1, 0, err_img(img_good));
    done_only();
    repeat (3) step();

    // vld and done together on the fourth beat
    reload();
    beat(W_A5, 0); beat('0, 0); beat('0, 0);
    push_res(1, 0, 0, 0, img_good);
    beat(W_TOP, 1);
    repeat (3) step();

    // Lock image, then a refused override
    reload();
    beat('0, 0); beat('0, 0); beat('0, 0); beat(W_LOCK, 0);
    push_res(1, 0, 0, 1, img_lock);
    done_only();
    repeat (3) step();
    blk_q.push_back(cyc + 1);
    push_snap(1, 0, 0, 1, img_lock, 2);
    ovr(2'd1, W_OVR);
    repeat (3) step();

    // Reload and override together: reload wins, no blocked pulse
    bus.rg_shadow_ovr_en = 1'b1;
    bus.rg_shadow_ovr_wr = 1'b1;
    reload();
    // Override during LOAD is refused
    blk_q.push_back(cyc + 1);
    beat(W_A5, 0);
    bus.rg_shadow_ovr_wr = 1'b0;
    bus.rg_shadow_ovr_en = 1'b0;
    beat('0, 0);

    // Reset mid-load
    rst_n = 1'b0;
    push_snap(0, 0, 0, 0, '0, 0);
    step();
    rst_n = 1'b1;
    step();

    // done with zero beats from IDLE
    push_res(0, 0, 1, 0, '0);
    done_only();
    repeat (3) step();

    // Recover with a good load
    reload();
    beat(W_A5, 0); beat('0, 0); beat('0, 0); beat(W_TOP, 0);
    push_res(1, 0, 0, 0, img_good);
    done_only();
    repeat (5) step();

    while (res_q.size() != 0)  begin void'(res_q.pop_front());  note_fail("res_missing"); end
    while (snap_q.size() != 0) begin void'(snap_q.pop_front()); note_fail("snap_missing"); end
    while (rr_q.size() != 0)   begin void'(rr_q.pop_front());   note_fail("reload_req_missing"); end
    while (blk_q.size() != 0)  begin void'(blk_q.pop_front());  note_fail("ovr_blocked_missing"); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
